// File: rtl/adder_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : adder_seq_pkg
// Brief  : State encoding and width helper for the sequential reduction ctrl.
// Rev    : 1.0
// ============================================================================
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to hold the values 0..max_ops inclusive.
    function automatic int cw_f(input int max_ops);
        return $clog2(max_ops + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/n_bit_adder.sv
`default_nettype none
// ============================================================================
// Module : n_bit_adder
// Brief  : N-bit combinational adder; carry-out is not produced (mod 2^N sum).
// Rev    : 1.0
// ============================================================================
module n_bit_adder #(
    parameter int N = 16
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Sum
);

    assign Sum = A + B;

endmodule
`default_nettype wire

// File: rtl/adder_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module : adder_seq_ctrl
// Brief  : Accumulates one operand per cycle through a shared adder and emits
//          the batch sum, operand count and overflow flag on valid/ready.
// Rev    : 1.0
// ============================================================================
module adder_seq_ctrl
    import adder_seq_pkg::*;
#(
    parameter int N       = 16,
    parameter int MAX_OPS = 8
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [N-1:0]                          in_data,
    input  logic                                  in_last,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [N-1:0]                          out_sum,
    output logic [adder_seq_pkg::cw_f(MAX_OPS)-1:0] out_count,
    output logic                                  out_err
);

    localparam int CW = cw_f(MAX_OPS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_acc;
    logic [CW-1:0]   r_count;
    logic            r_err;
    logic [N-1:0]    w_sum;
    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_full;

    assign in_ready   = (r_state != DONE);
    assign out_valid  = (r_state == DONE);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_full     = (r_count == CW'(MAX_OPS));

    n_bit_adder #(.N(N)) u_adder (
        .A   (r_acc),
        .B   (in_data),
        .Sum (w_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = in_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_in_fire && in_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Beats past MAX_OPS are still accepted so the source can finish the
    // batch, but they only raise the error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_out_fire) begin
            r_acc   <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else if (w_in_fire) begin
            if (w_full) begin
                r_err <= 1'b1;
            end else begin
                r_acc   <= w_sum;
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign out_sum   = r_acc;
    assign out_count = r_count;
    assign out_err   = r_err;

endmodule
`default_nettype wire
